// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite attribute scan that picks up to SLOTS covering sprites and commits them atomically
module sprite_line_scheduler #(
  parameter int MAX_SPRITES = 8,
  parameter int SLOTS = 4,
  localparam int IW = $clog2(MAX_SPRITES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [9:0]            next_y,
  output logic                  tbl_rd,
  output logic [IW-1:0]         tbl_idx,
  input  logic                  tbl_en,
  input  logic [9:0]            tbl_y,
  input  logic [3:0]            tbl_h,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [SLOTS*IW-1:0]   slot_id,
  output logic [SLOTS*4-1:0]    slot_row,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int CW = $clog2(SLOTS + 1);
  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;
  state_t                state;
  logic [9:0]            y;
  logic [IW-1:0]         i;
  logic [CW-1:0]         cnt;
  logic [SLOTS-1:0]      st_valid, n_valid;
  logic [SLOTS*IW-1:0]   st_id, n_id;
  logic [SLOTS*4-1:0]    st_row, n_row;
  logic [9:0]            diff;
  logic                  hit, full, last;
  assign diff = y - tbl_y;
  assign hit  = tbl_en && diff <= {6'b0, tbl_h};
  assign full = cnt == CW'(SLOTS);
  assign last = i == IW'(MAX_SPRITES - 1);
  // staging slots as they stand after the entry under evaluation is accepted
  always_comb begin
    n_valid = st_valid;
    n_id    = st_id;
    n_row   = st_row;
    for (int k = 0; k < SLOTS; k++)
      if (hit && !full && cnt == CW'(k)) begin
        n_valid[k]          = 1'b1;
        n_id[k*IW +: IW]    = i;
        n_row[k*4 +: 4]     = diff[3:0];
      end
  end
  // scan FSM; a hit with all slots taken ends the scan, and the commit happens on the edge into DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      y          <= '0;
      i          <= '0;
      cnt        <= '0;
      st_valid   <= '0;
      st_id      <= '0;
      st_row     <= '0;
      slot_valid <= '0;
      slot_id    <= '0;
      slot_row   <= '0;
      tbl_rd     <= 1'b0;
      tbl_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done   <= 1'b0;
      tbl_rd <= 1'b0;
      if (line_start) begin
        state    <= READ;
        y        <= next_y;
        i        <= '0;
        cnt      <= '0;
        st_valid <= '0;
        st_id    <= '0;
        st_row   <= '0;
        tbl_rd   <= 1'b1;
        tbl_idx  <= '0;
        busy     <= 1'b1;
      end else begin
        case (state)
          READ: state <= EVAL;
          EVAL: begin
            st_valid <= n_valid;
            st_id    <= n_id;
            st_row   <= n_row;
            cnt      <= (hit && !full) ? cnt + 1'b1 : cnt;
            if ((hit && full) || last) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              slot_valid <= n_valid;
              slot_id    <= n_id;
              slot_row   <= n_row;
              overflow   <= hit && full;
            end else begin
              state   <= READ;
              i       <= i + 1'b1;
              tbl_rd  <= 1'b1;
              tbl_idx <= i + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: scoreboard bench with a behavioural attribute table and scan model
module tb_sprite_line_scheduler;
  localparam int MS = 8, SL = 4, IW = 3;
  logic clk = 0, reset = 1, line_start = 0;
  logic [9:0] next_y = '0;
  logic tbl_rd, busy, done, overflow;
  logic [IW-1:0] tbl_idx;
  logic tbl_en = 0;
  logic [9:0] tbl_y = '0;
  logic [3:0] tbl_h = '0;
  logic [SL-1:0] slot_valid;
  logic [SL*IW-1:0] slot_id;
  logic [SL*4-1:0] slot_row;
  logic m_en [MS];
  logic [9:0] m_y [MS];
  logic [3:0] m_h [MS];
  typedef struct {
    logic [SL-1:0] v;
    logic [SL*IW-1:0] id;
    logic [SL*4-1:0] row;
    logic ovf;
    int dcyc;
  } exp_t;
  exp_t q[$];
  exp_t com;
  int cyc = 0, total = 0, bad = 0;

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .line_start(line_start), .next_y(next_y),
    .tbl_rd(tbl_rd), .tbl_idx(tbl_idx), .tbl_en(tbl_en), .tbl_y(tbl_y), .tbl_h(tbl_h),
    .slot_valid(slot_valid), .slot_id(slot_id), .slot_row(slot_row),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // table answers one cycle after a read; otherwise it presents junk
  always @(posedge clk)
    if (tbl_rd) {tbl_en, tbl_y, tbl_h} <= {m_en[tbl_idx], m_y[tbl_idx], m_h[tbl_idx]};
    else {tbl_en, tbl_y, tbl_h} <= 15'($urandom);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [9:0] ny, int n);
    exp_t e;
    int c;
    logic [9:0] d;
    c = 0;
    e.v = '0; e.id = '0; e.row = '0; e.ovf = 0; e.dcyc = n + 2*MS + 1;
    for (int j = 0; j < MS; j++) begin
      d = ny - m_y[j];
      if (m_en[j] && d <= {6'b0, m_h[j]}) begin
        if (c == SL) begin
          e.ovf = 1; e.dcyc = n + 3 + 2*j;
          break;
        end
        e.v[c] = 1'b1;
        e.id[c*IW +: IW] = IW'(j);
        e.row[c*4 +: 4] = d[3:0];
        c++;
      end
    end
    return e;
  endfunction

  // called #1 after a posedge; pulses line_start for that cycle and drops scans it aborts
  task automatic start(logic [9:0] ny);
    while (q.size() > 0 && q[$].dcyc > cyc) void'(q.pop_back());
    q.push_back(model(ny, cyc));
    line_start = 1; next_y = ny;
    @(posedge clk); #1;
    line_start = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 40) begin @(posedge clk); t++; end
    #1;
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic clear_tbl();
    for (int j = 0; j < MS; j++) begin m_en[j] = 0; m_y[j] = '0; m_h[j] = '0; end
  endtask

  always @(negedge clk) if (!reset) begin
    if (q.size() > 0 && q[0].dcyc < cyc) begin
      check("done_missing", 0, 1);
      void'(q.pop_front());
    end
    if (done) begin
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        com = q.pop_front();
        check("done_cycle", cyc, com.dcyc);
        check("busy_at_done", busy, 0);
      end
    end
    check("slot_valid", slot_valid, com.v);
    check("slot_id", slot_id, com.id);
    check("slot_row", slot_row, com.row);
    check("overflow", overflow, com.ovf);
  end

  initial begin
    com = '{v: '0, id: '0, row: '0, ovf: 0, dcyc: 0};
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", slot_valid, 0);
    check("rst_id", slot_id, 0);
    check("rst_row", slot_row, 0);
    check("rst_ctl", {tbl_rd, tbl_idx, busy, done, overflow}, 0);
    reset = 0;
    @(posedge clk); #1;
    m_en[2] = 1; m_y[2] = 100; m_h[2] = 15;
    start(107);
    check("busy_scan", busy, 1);
    check("rd_first", {tbl_rd, tbl_idx}, {1'b1, 3'd0});
    drain();
    foreach (m_h[j]) begin end
    start(100); drain();
    start(115); drain();
    start(116); drain();
    start(99);  drain();
    clear_tbl();
    for (int j = 0; j < 6; j++) begin m_en[j] = 1; m_y[j] = 50; m_h[j] = 3; end
    start(51); drain();
    clear_tbl();
    m_en[0] = 0; m_y[0] = 0; m_h[0] = 15;
    start(0); drain();
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < MS; j++) begin
        m_en[j] = 1'($urandom); m_y[j] = 10'($urandom_range(90, 130)); m_h[j] = 4'($urandom);
      end
      start(10'($urandom_range(85, 140))); drain();
    end
    clear_tbl();
    m_en[1] = 1; m_y[1] = 200; m_h[1] = 9;
    m_en[6] = 1; m_y[6] = 300; m_h[6] = 4;
    start(203);
    repeat (3) @(posedge clk);
    #1;
    start(302);
    drain();
    start(205);
    repeat (15) @(posedge clk);
    #1;
    start(301);
    drain();
    start(201);
    repeat (4) @(posedge clk);
    #1;
    reset = 1;
    q.delete();
    com = '{v: '0, id: '0, row: '0, ovf: 0, dcyc: 0};
    @(posedge clk); #1;
    reset = 0;
    check("rst_mid_valid", slot_valid, 0);
    check("rst_mid_ctl", {tbl_rd, tbl_idx, busy, done, overflow}, 0);
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    start(304); drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
